// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer for the traffic-light sequencer: holds tBASE/tEXT/tYEL,
// maps the FSM interval code to seconds, counts down on a 1 s tick and pulses expired.
module interval_timer_ctrl #(
  parameter int         TICK_DIV = 100_000_000,
  parameter logic [3:0] DEF_BASE = 4'd6,
  parameter logic [3:0] DEF_EXT  = 4'd3,
  parameter logic [3:0] DEF_YEL  = 4'd2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Prog_Sync,
  input  logic [1:0] Time_Param_Sel,
  input  logic [3:0] Time_Value,
  input  logic [1:0] interval,
  input  logic       start_timer,
  output logic       expired,
  output logic       one_sec_tick,
  output logic [4:0] remaining
);

  localparam int                DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       rem_q, rem_d;
  logic             expired_q, expired_d;
  logic             tick_q, tick_d;
  logic [3:0]       p_base_q, p_base_d;
  logic [3:0]       p_ext_q, p_ext_d;
  logic [3:0]       p_yel_q, p_yel_d;
  logic [4:0]       duration;

  // Parameter writes land first so a same-cycle start loads the new value.
  always_comb begin
    p_base_d = p_base_q;
    p_ext_d  = p_ext_q;
    p_yel_d  = p_yel_q;
    if (Prog_Sync) begin
      case (Time_Param_Sel)
        2'b00:   p_base_d = (Time_Value == 4'd0) ? DEF_BASE : Time_Value;
        2'b01:   p_ext_d  = (Time_Value == 4'd0) ? DEF_EXT  : Time_Value;
        2'b10:   p_yel_d  = (Time_Value == 4'd0) ? DEF_YEL  : Time_Value;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (interval)
      2'b00:   duration = {1'b0, p_base_d};
      2'b01:   duration = {1'b0, p_ext_d};
      2'b10:   duration = {1'b0, p_yel_d};
      default: duration = {p_base_d, 1'b0};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    rem_d     = rem_q;
    expired_d = 1'b0;
    tick_d    = 1'b0;
    if (start_timer) begin
      state_d = COUNT;
      div_d   = '0;
      rem_d   = duration;
    end else if (Prog_Sync) begin
      state_d = IDLE;
      div_d   = '0;
      rem_d   = 5'd0;
    end else if (state_q == COUNT) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
        if (rem_q <= 5'd1) begin
          rem_d     = 5'd0;
          expired_d = (rem_q == 5'd1);
          state_d   = IDLE;
        end else begin
          rem_d = rem_q - 5'd1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end else begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      rem_q     <= 5'd0;
      expired_q <= 1'b0;
      tick_q    <= 1'b0;
      p_base_q  <= DEF_BASE;
      p_ext_q   <= DEF_EXT;
      p_yel_q   <= DEF_YEL;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      rem_q     <= rem_d;
      expired_q <= expired_d;
      tick_q    <= tick_d;
      p_base_q  <= p_base_d;
      p_ext_q   <= p_ext_d;
      p_yel_q   <= p_yel_d;
    end
  end

  assign expired      = expired_q;
  assign one_sec_tick = tick_q;
  assign remaining    = rem_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl with TICK_DIV=4; inputs driven and outputs
// sampled on the falling edge.
module tb_interval_timer_ctrl;

  logic       clk = 1'b0;
  logic       Reset;
  logic       Prog_Sync;
  logic [1:0] Time_Param_Sel;
  logic [3:0] Time_Value;
  logic [1:0] interval;
  logic       start_timer;
  logic       expired;
  logic       one_sec_tick;
  logic [4:0] remaining;

  int checks = 0;
  int errors = 0;
  int cyc;
  int ticks;

  interval_timer_ctrl #(
    .TICK_DIV(4),
    .DEF_BASE(4'd6),
    .DEF_EXT (4'd3),
    .DEF_YEL (4'd2)
  ) dut (
    .clk           (clk),
    .Reset         (Reset),
    .Prog_Sync     (Prog_Sync),
    .Time_Param_Sel(Time_Param_Sel),
    .Time_Value    (Time_Value),
    .interval      (interval),
    .start_timer   (start_timer),
    .expired       (expired),
    .one_sec_tick  (one_sec_tick),
    .remaining     (remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start is sampled by the next rising edge (E0); returns at the falling edge after E0.
  task automatic start_run(input logic [1:0] iv);
    interval    = iv;
    start_timer = 1'b1;
    @(negedge clk);
    start_timer = 1'b0;
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] val);
    Prog_Sync      = 1'b1;
    Time_Param_Sel = sel;
    Time_Value     = val;
    @(negedge clk);
    Prog_Sync = 1'b0;
  endtask

  // Counts edges after E0 until expired is seen; bounded by max_cyc.
  task automatic wait_expire(input int max_cyc, output int n, output int t);
    n = 0;
    t = 0;
    do begin
      @(negedge clk);
      n++;
      if (one_sec_tick) t++;
    end while (expired !== 1'b1 && n < max_cyc);
  endtask

  initial begin
    Reset          = 1'b1;
    Prog_Sync      = 1'b0;
    Time_Param_Sel = 2'b00;
    Time_Value     = 4'd0;
    interval       = 2'b00;
    start_timer    = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    check("reset_remaining", remaining, 0);
    check("reset_expired", expired, 0);
    check("reset_tick", one_sec_tick, 0);

    // Default tBASE: tick every 4 edges, remaining 6 -> 0, expired after edge E0+24
    start_run(2'b00);
    check("base_load", remaining, 6);
    check("base_load_exp", expired, 0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check($sformatf("base_tick_%0d", k), one_sec_tick, (k % 4 == 0) ? 1 : 0);
      check($sformatf("base_rem_%0d", k), remaining, 6 - k / 4);
      check($sformatf("base_exp_%0d", k), expired, (k == 24) ? 1 : 0);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("base_after_exp", expired, 0);
    end
    $display("base: default tBASE countdown done");

    // Programmed tYEL = 5, then restored to default 2
    prog(2'b10, 4'd5);
    start_run(2'b10);
    check("yel5_load", remaining, 5);
    wait_expire(40, cyc, ticks);
    check("yel5_latency", cyc, 20);
    check("yel5_ticks", ticks, 5);
    @(negedge clk);
    prog(2'b10, 4'd0);
    start_run(2'b10);
    check("yel_def_load", remaining, 2);
    wait_expire(30, cyc, ticks);
    check("yel_def_latency", cyc, 8);
    $display("yel: programmed 5 then default 2");

    // 2 x tBASE with tBASE = 15 -> 30 s, no wrap
    @(negedge clk);
    prog(2'b00, 4'd15);
    start_run(2'b11);
    check("dbl_load", remaining, 30);
    wait_expire(140, cyc, ticks);
    check("dbl_latency", cyc, 120);
    check("dbl_ticks", ticks, 30);
    $display("dbl: 2xtBASE=30 countdown done");

    // Back-to-back tEXT starts in the cycle right after each expired
    @(negedge clk);
    start_run(2'b01);
    wait_expire(30, cyc, ticks);
    check("b2b_first", cyc, 12);
    for (int r = 0; r < 3; r++) begin
      start_run(2'b01);
      check("b2b_reload", remaining, 3);
      check("b2b_exp_low", expired, 0);
      wait_expire(30, cyc, ticks);
      check($sformatf("b2b_period_%0d", r), cyc, 12);
    end
    $display("b2b: expired every 12 cycles");

    // Restart of a tBASE count at E0+10 moves expiry to E0+34
    @(negedge clk);
    prog(2'b00, 4'd0);
    start_run(2'b00);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("restart_pre_exp", expired, 0);
    end
    start_run(2'b00);
    check("restart_reload", remaining, 6);
    wait_expire(44, cyc, ticks);
    check("restart_latency", cyc, 24);
    $display("restart: expiry moved to E0+34");

    // Abort with reserved select mid-count
    @(negedge clk);
    start_run(2'b00);
    repeat (5) @(negedge clk);
    prog(2'b11, 4'd7);
    check("abort_remaining", remaining, 0);
    check("abort_expired", expired, 0);
    cyc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (expired || one_sec_tick) cyc++;
    end
    check("abort_quiet", cyc, 0);
    start_run(2'b00);
    check("abort_base_kept", remaining, 6);
    start_run(2'b01);
    check("abort_ext_kept", remaining, 3);
    start_run(2'b10);
    check("abort_yel_kept", remaining, 2);
    // Same-cycle write and start: start sees the new tBASE
    Prog_Sync      = 1'b1;
    Time_Param_Sel = 2'b00;
    Time_Value     = 4'd9;
    start_run(2'b00);
    Prog_Sync = 1'b0;
    check("wr_start_load", remaining, 9);
    $display("abort: reserved select and same-cycle write/start done");

    // Asynchronous reset mid-count
    prog(2'b01, 4'd7);
    prog(2'b10, 4'd4);
    start_run(2'b00);
    repeat (10) @(negedge clk);
    #2 Reset = 1'b1;
    #1;
    check("areset_remaining", remaining, 0);
    check("areset_expired", expired, 0);
    check("areset_tick", one_sec_tick, 0);
    @(negedge clk);
    Reset = 1'b0;
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (expired) cyc++;
    end
    check("areset_no_exp", cyc, 0);
    start_run(2'b00);
    check("areset_base_def", remaining, 6);
    start_run(2'b01);
    check("areset_ext_def", remaining, 3);
    start_run(2'b10);
    check("areset_yel_def", remaining, 2);
    start_run(2'b11);
    check("areset_dbl_def", remaining, 12);
    $display("areset: state and parameters restored");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
